// File: rtl/decode_pipe_stage.sv
// ID stage: decodes one RV32I (optionally RV32M) instruction per cycle into the
// ID/EX register, with valid/ready handshake, load-use bubbling and flush.
module decode_pipe_stage #(
    parameter int XLEN      = 32,
    parameter int ENABLE_M  = 0,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_offset,
    output logic              out_MemtoReg,
    output logic              out_RegWrite,
    output logic              out_MemWrite,
    output logic              out_MemRead,
    output logic              out_Jump,
    output logic              out_JALR,
    output logic              out_Branch,
    output logic              out_ALUSrcA,
    output logic [1:0]        out_ALUSrcB,
    output logic [4:0]        out_ALUCode,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_LUI  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_r, is_i, is_lw, is_sw, is_sb, is_jalr, is_jal, is_lui, is_auipc;
    logic       known_op;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_sb    = (opcode == OP_SB);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign known_op = is_r | is_i | is_lw | is_sw | is_sb | is_jalr | is_jal | is_lui | is_auipc;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;

    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign shamt = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

    logic [4:0] alu_code;
    logic       bad_funct7;
    logic       illegal;

    // ALU operation plus R-type funct7 legality; funct7=0100000 is only sub/sra.
    always_comb begin
        alu_code   = ALU_ADD;
        bad_funct7 = 1'b0;
        if (is_r || is_i) begin
            case (funct3)
                3'd0:    alu_code = (is_r && in_instr[30]) ? ALU_SUB : ALU_ADD;
                3'd1:    alu_code = ALU_SLL;
                3'd2:    alu_code = ALU_SLT;
                3'd3:    alu_code = ALU_SLTU;
                3'd4:    alu_code = ALU_XOR;
                3'd5:    alu_code = in_instr[30] ? ALU_SRA : ALU_SRL;
                3'd6:    alu_code = ALU_OR;
                default: alu_code = ALU_AND;
            endcase
        end
        if (is_r) begin
            if (funct7 == 7'b0000001) begin
                if (ENABLE_M != 0) begin
                    alu_code = {2'b10, funct3};
                end else begin
                    bad_funct7 = 1'b1;
                end
            end else if (funct7 == 7'b0100000) begin
                if (funct3 != 3'd0 && funct3 != 3'd5) begin
                    bad_funct7 = 1'b1;
                end
            end else if (funct7 != 7'b0000000) begin
                bad_funct7 = 1'b1;
            end
        end else if (is_lui) begin
            alu_code = ALU_LUI;
        end
    end

    assign illegal = ~known_op | bad_funct7;

    logic [XLEN-1:0] d_imm, d_offset;
    logic            d_reg_write, d_mem_write, d_mem_read, d_jump, d_branch;
    logic [1:0]      d_src_b;
    logic [4:0]      d_alu_code;

    assign d_imm = is_i                  ? ((funct3 == 3'd1 || funct3 == 3'd5) ? shamt : imm_i) :
                   is_lw                 ? imm_i :
                   is_sw                 ? imm_s :
                   (is_lui || is_auipc)  ? imm_u : '0;
    assign d_offset = is_jalr ? imm_i :
                      is_jal  ? imm_j :
                      is_sb   ? imm_b : '0;

    // An illegal instruction still travels down the pipe but must not change state.
    assign d_reg_write = ~illegal & (is_r | is_i | is_lw | is_jalr | is_lui | is_auipc | is_jal);
    assign d_mem_write = ~illegal & is_sw;
    assign d_mem_read  = ~illegal & is_lw;
    assign d_jump      = ~illegal & (is_jal | is_jalr);
    assign d_branch    = ~illegal & is_sb;
    assign d_alu_code  = illegal ? ALU_ADD : alu_code;
    assign d_src_b     = {is_jal | is_jalr, ~(is_r | is_jal | is_jalr)};

    logic uses_rs1, uses_rs2, stall, advance;

    assign uses_rs1 = is_r | is_i | is_lw | is_sw | is_sb | is_jalr;
    assign uses_rs2 = is_r | is_sw | is_sb;
    assign advance  = ~out_valid | ex_ready;
    assign stall    = (HAZARD_EN != 0) & in_valid & out_valid & out_MemRead & (out_rd != 5'd0) &
                      ((uses_rs1 & (in_instr[19:15] == out_rd)) |
                       (uses_rs2 & (in_instr[24:20] == out_rd)));
    assign in_ready = flush | (advance & ~stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_imm      <= '0;
            out_offset   <= '0;
            out_MemtoReg <= 1'b0;
            out_RegWrite <= 1'b0;
            out_MemWrite <= 1'b0;
            out_MemRead  <= 1'b0;
            out_Jump     <= 1'b0;
            out_JALR     <= 1'b0;
            out_Branch   <= 1'b0;
            out_ALUSrcA  <= 1'b0;
            out_ALUSrcB  <= '0;
            out_ALUCode  <= '0;
            out_illegal  <= 1'b0;
            stall_cnt    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance && stall) begin
            out_valid <= 1'b0;
            if (stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end else if (advance) begin
            out_valid    <= in_valid;
            out_pc       <= in_pc;
            out_rs1      <= in_instr[19:15];
            out_rs2      <= in_instr[24:20];
            out_rd       <= in_instr[11:7];
            out_imm      <= d_imm;
            out_offset   <= d_offset;
            out_MemtoReg <= d_mem_read;
            out_RegWrite <= d_reg_write;
            out_MemWrite <= d_mem_write;
            out_MemRead  <= d_mem_read;
            out_Jump     <= d_jump;
            out_JALR     <= ~illegal & is_jalr;
            out_Branch   <= d_branch;
            out_ALUSrcA  <= is_jal | is_jalr | is_auipc;
            out_ALUSrcB  <= d_src_b;
            out_ALUCode  <= d_alu_code;
            out_illegal  <= illegal;
        end
    end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: instance A (defaults) and instance B (RV32M on,
// hazard detection off) share stimulus and are checked against an instruction-level model.
module tb_decode_pipe_stage;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [15:0] cnt;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] offset;
        logic        mtr;
        logic        rw;
        logic        mw;
        logic        mr;
        logic        jump;
        logic        jalr;
        logic        branch;
        logic        src_a;
        logic [1:0]  src_b;
        logic [4:0]  alu;
        logic        illegal;
    } obs_t;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        fl;
        logic        exr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_mtr, a_rw, a_mw, a_mr, a_j, a_jalr, a_br, a_sa, a_ill;
    logic [31:0] a_pc, a_imm, a_off;
    logic [4:0]  a_rs1, a_rs2, a_rd, a_alu;
    logic [1:0]  a_sb;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_mtr, b_rw, b_mw, b_mr, b_j, b_jalr, b_br, b_sa, b_ill;
    logic [31:0] b_pc, b_imm, b_off;
    logic [4:0]  b_rs1, b_rs2, b_rd, b_alu;
    logic [1:0]  b_sb;
    logic [15:0] b_cnt;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    obs_t mod_a = '0;
    obs_t mod_b = '0;
    obs_t obs_a, obs_b;

    always #5 clk = ~clk;

    decode_pipe_stage #(.XLEN(32), .ENABLE_M(0), .HAZARD_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready),
        .out_valid(a_out_valid), .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_rd(a_rd), .out_imm(a_imm), .out_offset(a_off), .out_MemtoReg(a_mtr),
        .out_RegWrite(a_rw), .out_MemWrite(a_mw), .out_MemRead(a_mr), .out_Jump(a_j),
        .out_JALR(a_jalr), .out_Branch(a_br), .out_ALUSrcA(a_sa), .out_ALUSrcB(a_sb),
        .out_ALUCode(a_alu), .out_illegal(a_ill), .stall_cnt(a_cnt)
    );

    decode_pipe_stage #(.XLEN(32), .ENABLE_M(1), .HAZARD_EN(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready),
        .out_valid(b_out_valid), .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_rd(b_rd), .out_imm(b_imm), .out_offset(b_off), .out_MemtoReg(b_mtr),
        .out_RegWrite(b_rw), .out_MemWrite(b_mw), .out_MemRead(b_mr), .out_Jump(b_j),
        .out_JALR(b_jalr), .out_Branch(b_br), .out_ALUSrcA(b_sa), .out_ALUSrcB(b_sb),
        .out_ALUCode(b_alu), .out_illegal(b_ill), .stall_cnt(b_cnt)
    );

    assign obs_a = {a_out_valid, a_in_ready, a_cnt, a_pc, a_rs1, a_rs2, a_rd, a_imm, a_off,
                    a_mtr, a_rw, a_mw, a_mr, a_j, a_jalr, a_br, a_sa, a_sb, a_alu, a_ill};
    assign obs_b = {b_out_valid, b_in_ready, b_cnt, b_pc, b_rs1, b_rs2, b_rd, b_imm, b_off,
                    b_mtr, b_rw, b_mw, b_mr, b_j, b_jalr, b_br, b_sa, b_sb, b_alu, b_ill};

    // Instruction-level meaning of one encoding, written per instruction class.
    function automatic obs_t modelDecode(input logic [31:0] ins, input bit m_en);
        obs_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        int         alu_of_f3 [8];
        d = '0;
        alu_of_f3 = '{0, 6, 9, 10, 4, 7, 5, 3};
        f3 = ins[14:12];
        f7 = ins[31:25];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                d.rw = 1'b1;
                if (f7 == 7'h00)                    d.alu = 5'(alu_of_f3[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 5'd8;
                else if (f7 == 7'h01 && m_en)       d.alu = 5'(16 + int'(f3));
                else                                d.illegal = 1'b1;
            end
            7'h13: begin
                d.rw = 1'b1; d.src_b = 2'b01;
                d.alu = (f3 == 3'd5 && ins[30]) ? 5'd8 : 5'(alu_of_f3[f3]);
                d.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
            end
            7'h03: begin
                d.rw = 1'b1; d.mr = 1'b1; d.mtr = 1'b1; d.src_b = 2'b01;
                d.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'h23: begin
                d.mw = 1'b1; d.src_b = 2'b01;
                d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'h63: begin
                d.branch = 1'b1; d.src_b = 2'b01;
                d.offset = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h67: begin
                d.rw = 1'b1; d.jump = 1'b1; d.jalr = 1'b1; d.src_a = 1'b1; d.src_b = 2'b10;
                d.offset = {{20{ins[31]}}, ins[31:20]};
            end
            7'h6F: begin
                d.rw = 1'b1; d.jump = 1'b1; d.src_a = 1'b1; d.src_b = 2'b10;
                d.offset = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h37: begin
                d.rw = 1'b1; d.src_b = 2'b01; d.alu = 5'd2; d.imm = {ins[31:12], 12'h000};
            end
            7'h17: begin
                d.rw = 1'b1; d.src_a = 1'b1; d.src_b = 2'b01; d.imm = {ins[31:12], 12'h000};
            end
            default: begin
                d.illegal = 1'b1; d.src_b = 2'b01;
            end
        endcase
        if (d.illegal) begin
            d.rw = 1'b0; d.mw = 1'b0; d.mr = 1'b0; d.jump = 1'b0; d.branch = 1'b0; d.alu = 5'd0;
        end
        return d;
    endfunction

    // bit0: reads rs1, bit1: reads rs2
    function automatic logic [1:0] modelUses(input logic [31:0] ins);
        case (ins[6:0])
            7'h33, 7'h23, 7'h63: return 2'b11;
            7'h13, 7'h03, 7'h67: return 2'b01;
            default:             return 2'b00;
        endcase
    endfunction

    function automatic logic modelStall(input obs_t s, input bit haz);
        logic [1:0] u;
        u = modelUses(in_instr);
        return haz && in_valid && s.valid && s.mr && (s.rd != 5'd0) &&
               ((u[0] && in_instr[19:15] == s.rd) || (u[1] && in_instr[24:20] == s.rd));
    endfunction

    function automatic logic modelReady(input obs_t s, input bit haz);
        return flush || ((!s.valid || ex_ready) && !modelStall(s, haz));
    endfunction

    function automatic obs_t modelStep(input obs_t s, input bit m_en, input bit haz);
        obs_t n;
        n = s;
        if (flush) begin
            n.valid = 1'b0;
        end else if ((!s.valid || ex_ready) && modelStall(s, haz)) begin
            n.valid = 1'b0;
            if (s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
        end else if (!s.valid || ex_ready) begin
            n = modelDecode(in_instr, m_en);
            n.valid = in_valid;
            n.pc = in_pc;
            n.cnt = s.cnt;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mod_a = '0;
            mod_b = '0;
        end else begin
            mod_a = modelStep(mod_a, 1'b0, 1'b1);
            mod_b = modelStep(mod_b, 1'b1, 1'b0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll(input string tag, input obs_t act, input obs_t exp, input logic rdy);
        checkOutput({tag, ".out_valid"}, 32'(act.valid), 32'(exp.valid));
        checkOutput({tag, ".in_ready"}, 32'(act.ready), 32'(rdy));
        checkOutput({tag, ".stall_cnt"}, 32'(act.cnt), 32'(exp.cnt));
        if (exp.valid) begin
            checkOutput({tag, ".pc"}, act.pc, exp.pc);
            checkOutput({tag, ".regs"}, 32'({act.rs1, act.rs2, act.rd}), 32'({exp.rs1, exp.rs2, exp.rd}));
            checkOutput({tag, ".imm"}, act.imm, exp.imm);
            checkOutput({tag, ".offset"}, act.offset, exp.offset);
            checkOutput({tag, ".ctrl"},
                        32'({act.mtr, act.rw, act.mw, act.mr, act.jump, act.jalr, act.branch, act.src_a, act.src_b}),
                        32'({exp.mtr, exp.rw, exp.mw, exp.mr, exp.jump, exp.jalr, exp.branch, exp.src_a, exp.src_b}));
            checkOutput({tag, ".alu"}, 32'(act.alu), 32'(exp.alu));
            checkOutput({tag, ".illegal"}, 32'(act.illegal), 32'(exp.illegal));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compareAll("A", obs_a, mod_a, modelReady(mod_a, 1'b1));
            compareAll("B", obs_b, mod_b, modelReady(mod_b, 1'b0));
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic fl, input logic exr);
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; ex_ready = exr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    vec_t table_v [25];

    initial begin
        table_v = '{
            '{1'b1, 32'h0020A423, 1'b0, 1'b1}, '{1'b1, 32'h123452B7, 1'b0, 1'b1},
            '{1'b1, 32'hFFFFF317, 1'b0, 1'b1}, '{1'b1, 32'hFFC100E7, 1'b0, 1'b1},
            '{1'b1, 32'h40628233, 1'b0, 1'b1}, '{1'b1, 32'h4062D233, 1'b0, 1'b1},
            '{1'b1, 32'h0020F3B3, 1'b0, 1'b1}, '{1'b1, 32'h40209233, 1'b0, 1'b1},
            '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b1}, '{1'b1, 32'hFFF0F093, 1'b0, 1'b0},
            '{1'b1, 32'hFFF0F093, 1'b0, 1'b1}, '{1'b1, 32'h8000A093, 1'b0, 1'b1},
            '{1'b1, 32'h01F15093, 1'b0, 1'b1}, '{1'b0, 32'h00000000, 1'b0, 1'b1},
            '{1'b1, 32'h0000A003, 1'b0, 1'b1}, '{1'b1, 32'h000001B3, 1'b0, 1'b1},
            '{1'b1, 32'h0000A283, 1'b0, 1'b1}, '{1'b1, 32'h0050A023, 1'b0, 1'b1},
            '{1'b1, 32'h0050A023, 1'b0, 1'b1}, '{1'b1, 32'h0000A283, 1'b0, 1'b1},
            '{1'b1, 32'h000012B7, 1'b0, 1'b1}, '{1'b1, 32'h0000A103, 1'b0, 1'b1},
            '{1'b1, 32'h022081B3, 1'b0, 1'b0}, '{1'b1, 32'h022081B3, 1'b0, 1'b1},
            '{1'b1, 32'h022081B3, 1'b0, 1'b1}
        };

        #1 reset = 1'b1;
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_valid", 32'(a_out_valid), 32'h0);
        checkOutput("reset_cnt", 32'(a_cnt), 32'h0);

        applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b1);
        tick();
        checkOutput("addi_valid", 32'(a_out_valid), 32'h1);
        checkOutput("addi_alu", 32'(a_alu), 32'h0);
        checkOutput("addi_imm", a_imm, 32'h5);
        checkOutput("addi_rw", 32'(a_rw), 32'h1);
        checkOutput("addi_srcb", 32'(a_sb), 32'h1);
        checkOutput("addi_rd", 32'(a_rd), 32'h1);

        applyStimulus(1'b1, 32'h40335293, 32'h104, 1'b0, 1'b1);
        tick();
        checkOutput("srai_alu", 32'(a_alu), 32'h8);
        checkOutput("srai_imm", a_imm, 32'h3);

        applyStimulus(1'b1, 32'h0000A103, 32'h108, 1'b0, 1'b1);
        tick();
        checkOutput("lw_memread", 32'(a_mr), 32'h1);
        checkOutput("lw_rd", 32'(a_rd), 32'h2);

        applyStimulus(1'b1, 32'h001101B3, 32'h10C, 1'b0, 1'b1);
        checkOutput("hazard_ready_a", 32'(a_in_ready), 32'h0);
        checkOutput("nohazard_ready_b", 32'(b_in_ready), 32'h1);
        tick();
        checkOutput("bubble_valid_a", 32'(a_out_valid), 32'h0);
        checkOutput("bubble_cnt_a", 32'(a_cnt), 32'h1);
        checkOutput("nobubble_valid_b", 32'(b_out_valid), 32'h1);
        checkOutput("nobubble_rd_b", 32'(b_rd), 32'h3);
        checkOutput("nobubble_cnt_b", 32'(b_cnt), 32'h0);
        checkOutput("after_bubble_ready_a", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("add_valid_a", 32'(a_out_valid), 32'h1);
        checkOutput("add_alu_a", 32'(a_alu), 32'h0);
        checkOutput("add_rd_a", 32'(a_rd), 32'h3);
        checkOutput("add_cnt_a", 32'(a_cnt), 32'h1);

        applyStimulus(1'b1, 32'h022081B3, 32'h110, 1'b0, 1'b1);
        tick();
        checkOutput("mul_illegal_a", 32'(a_ill), 32'h1);
        checkOutput("mul_rw_a", 32'(a_rw), 32'h0);
        checkOutput("mul_alu_b", 32'(b_alu), 32'd16);
        checkOutput("mul_rw_b", 32'(b_rw), 32'h1);
        checkOutput("mul_illegal_b", 32'(b_ill), 32'h0);

        applyStimulus(1'b1, 32'h008000EF, 32'h200, 1'b0, 1'b1);
        tick();
        checkOutput("jal_offset", a_off, 32'h8);
        checkOutput("jal_jump", 32'(a_j), 32'h1);
        checkOutput("jal_srca", 32'(a_sa), 32'h1);
        checkOutput("jal_srcb", 32'(a_sb), 32'h2);

        applyStimulus(1'b1, 32'hFE000EE3, 32'h204, 1'b0, 1'b1);
        tick();
        checkOutput("beq_offset", a_off, 32'hFFFFFFFC);
        checkOutput("beq_branch", 32'(a_br), 32'h1);
        checkOutput("beq_pc", a_pc, 32'h204);

        applyStimulus(1'b1, 32'h0020A423, 32'h208, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_ready", 32'(a_in_ready), 32'h0);
            tick();
            checkOutput("hold_valid", 32'(a_out_valid), 32'h1);
            checkOutput("hold_offset", a_off, 32'hFFFFFFFC);
            checkOutput("hold_pc", a_pc, 32'h204);
        end
        applyStimulus(1'b1, 32'h0020A423, 32'h208, 1'b1, 1'b0);
        checkOutput("flush_ready", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("flush_valid", 32'(a_out_valid), 32'h0);

        // Stall while execute is blocked counts nothing; flush overrides a stall.
        applyStimulus(1'b1, 32'h0000A103, 32'h300, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h001101B3, 32'h304, 1'b0, 1'b0);
        checkOutput("blocked_stall_ready", 32'(a_in_ready), 32'h0);
        tick();
        checkOutput("blocked_stall_valid", 32'(a_out_valid), 32'h1);
        checkOutput("blocked_stall_cnt", 32'(a_cnt), 32'h1);
        applyStimulus(1'b1, 32'h001101B3, 32'h304, 1'b1, 1'b1);
        checkOutput("flush_stall_ready", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("flush_stall_valid", 32'(a_out_valid), 32'h0);
        checkOutput("flush_stall_cnt", 32'(a_cnt), 32'h1);

        applyStimulus(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b1);
        tick();
        checkOutput("pre_reset_valid", 32'(a_out_valid), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", 32'(a_out_valid), 32'h0);
        checkOutput("async_reset_imm", a_imm, 32'h0);
        checkOutput("async_reset_pc", a_pc, 32'h0);
        checkOutput("async_reset_rw", 32'(a_rw), 32'h0);
        checkOutput("async_reset_cnt", 32'(a_cnt), 32'h0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(table_v[i].v, table_v[i].ins, 32'h500 + 32'(i * 4), table_v[i].fl, table_v[i].exr);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("final_cnt_a", 32'(a_cnt), 32'h2);
        checkOutput("final_cnt_b", 32'(b_cnt), 32'h0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
